codec_init_sequencer: RTL and testbench

//  Power-up configuration sequencer for the audio codec. Walks a fixed table of

---
 rtl/audio_cfg_pkg.sv | 25 ++
 rtl/codec_init_rom.sv | 47 ++++
 rtl/codec_init_sequencer.sv | 154 +++++++++++++++
 tb/tb_codec_init_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_cfg_pkg.sv
// Shared types and constants for the codec power-up configuration path.
package audio_cfg_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_PWR,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } init_state_e;

  localparam int unsigned CFG_ENTRY_W    = 16;
  localparam logic [6:0]  CODEC_DEV_ADDR = 7'h1A;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m == 0) ? 1 : m;
  endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Codec register write table, one {reg_addr, data} entry per index, registered read.
module codec_init_rom
  import audio_cfg_pkg::*;
#(
  parameter int unsigned NUM_WRITES = 10,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [CFG_ENTRY_W-1:0] entry_o
);

  logic [CFG_ENTRY_W-1:0] entry_d, entry_q;

  // Indices past NUM_WRITES (or past the populated table) read as zero.
  always_comb begin
    entry_d = '0;
    if (32'(idx_i) < NUM_WRITES) begin
      case (32'(idx_i))
        32'd0:   entry_d = 16'h1E00;
        32'd1:   entry_d = 16'h0C10;
        32'd2:   entry_d = 16'h0E02;
        32'd3:   entry_d = 16'h1000;
        32'd4:   entry_d = 16'h0A00;
        32'd5:   entry_d = 16'h0812;
        32'd6:   entry_d = 16'h0017;
        32'd7:   entry_d = 16'h0217;
        32'd8:   entry_d = 16'h0479;
        32'd9:   entry_d = 16'h1201;
        default: entry_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
    end else if (en_i) begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/codec_init_sequencer.sv
// Power-up sequencer: walks the codec write table over the I2C master handshake,
// retrying NACKed or timed-out writes, and reports done or error.
module codec_init_sequencer
  import audio_cfg_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = CODEC_DEV_ADDR,
  parameter int unsigned NUM_WRITES     = 10,
  parameter int unsigned STARTUP_DELAY  = 1_000_000,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                i2c_req,
  input  logic                                i2c_ready,
  output logic [6:0]                          i2c_dev_addr,
  output logic [7:0]                          i2c_reg_addr,
  output logic [7:0]                          i2c_wdata,
  input  logic                                i2c_done,
  input  logic                                i2c_nack,
  output logic                                busy,
  output logic                                init_done,
  output logic                                init_err,
  output logic [$clog2(NUM_WRITES+1)-1:0]     step_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_WRITES + 1);
  localparam int unsigned CNT_W = $clog2(max3(STARTUP_DELAY, TIMEOUT_CYCLES, GAP_CYCLES) + 1);
  localparam int unsigned RET_W = $clog2(MAX_RETRIES + 1);
  localparam init_state_e AFTER_XFER = (GAP_CYCLES == 0) ? ST_LOAD : ST_GAP;

  init_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RET_W-1:0]       retry_q, retry_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   rom_en;
  logic [CFG_ENTRY_W-1:0] entry;

  codec_init_rom #(
    .NUM_WRITES (NUM_WRITES),
    .IDX_W      (IDX_W)
  ) u_rom (
    .clk     (clk),
    .rst     (rst),
    .en_i    (rom_en),
    .idx_i   (idx_q),
    .entry_o (entry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT_PWR;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    done_d  = done_q;
    err_d   = err_q;
    rom_en  = 1'b0;
    unique case (state_q)
      ST_WAIT_PWR: begin
        if (32'(cnt_q) + 32'd1 >= STARTUP_DELAY) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        rom_en  = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Counter starts at 1 so it equals cycles elapsed since the accept edge.
        if (i2c_ready) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i2c_done && !i2c_nack) begin
          retry_d = '0;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          if (idx_q == IDX_W'(NUM_WRITES - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = AFTER_XFER;
          end
        end else if (i2c_done || (32'(cnt_q) >= TIMEOUT_CYCLES)) begin
          retry_d = retry_q + RET_W'(1);
          cnt_d   = '0;
          if (32'(retry_q) + 32'd1 >= MAX_RETRIES) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = AFTER_XFER;
          end
        end
      end
      ST_GAP: begin
        if (32'(cnt_q) + 32'd1 >= GAP_CYCLES) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD;
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_WAIT_PWR;
    endcase
  end

  assign i2c_req      = (state_q == ST_ISSUE);
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_reg_addr = entry[15:8];
  assign i2c_wdata    = entry[7:0];
  assign busy         = (state_q != ST_DONE) && (state_q != ST_ERROR);
  assign init_done    = done_q;
  assign init_err     = err_q;
  assign step_idx     = idx_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: I2C master model, cycle-accurate expectation model, directed scenarios.
module tb_codec_init_sequencer;

  localparam int SD  = 20;
  localparam int GAP = 4;
  localparam int NW  = 4;
  localparam int TO  = 200;
  localparam int MR  = 3;
  localparam int IW  = $clog2(NW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          i2c_ready = 1'b0;
  logic          i2c_done = 1'b0;
  logic          i2c_nack = 1'b0;
  logic          i2c_req, busy, init_done, init_err;
  logic [6:0]    dev;
  logic [7:0]    ra, wd;
  logic [IW-1:0] step;

  codec_init_sequencer #(
    .DEV_ADDR       (7'h1A),
    .NUM_WRITES     (NW),
    .STARTUP_DELAY  (SD),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRIES    (MR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .i2c_req      (i2c_req),
    .i2c_ready    (i2c_ready),
    .i2c_dev_addr (dev),
    .i2c_reg_addr (ra),
    .i2c_wdata    (wd),
    .i2c_done     (i2c_done),
    .i2c_nack     (i2c_nack),
    .busy         (busy),
    .init_done    (init_done),
    .init_err     (init_err),
    .step_idx     (step)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [NW] = '{16'h1E00, 16'h0C10, 16'h0E02, 16'h1000};

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Master model configuration and transaction log
  int          ack_lat    = 50;
  bit          never_done = 1'b0;
  int          hold       = 0;
  int          nack_left [NW];
  logic [15:0] acc_log [$];
  int          acc_cyc [$];
  int          acc_run [$];

  // Expectation model: cycle arithmetic on when the request must be up
  int mc = 0;
  bit m_valid = 1'b0;
  bit m_wait, m_fly, m_done, m_err;
  int m_req_at, m_acc, m_idx, m_tries;

  always @(posedge clk) begin
    bit req_prev;
    req_prev = m_wait && (mc >= m_req_at);
    if (rst) begin
      mc = 0; m_valid = 1'b1; m_wait = 1'b1; m_req_at = SD + 1; m_fly = 1'b0;
      m_done = 1'b0; m_err = 1'b0; m_idx = 0; m_tries = 0; m_acc = 0;
    end else begin
      mc++;
      if (m_done || m_err) begin
        if (start) begin
          m_done = 1'b0; m_err = 1'b0; m_idx = 0; m_tries = 0;
          m_wait = 1'b1; m_req_at = mc + 1;
        end
      end else if (m_fly) begin
        if (i2c_done && !i2c_nack) begin
          m_fly = 1'b0; m_idx++; m_tries = 0;
          if (m_idx == NW) m_done = 1'b1;
          else begin m_wait = 1'b1; m_req_at = mc + GAP + 1; end
        end else if (i2c_done || (mc - m_acc >= TO)) begin
          m_fly = 1'b0; m_tries++;
          if (m_tries == MR) m_err = 1'b1;
          else begin m_wait = 1'b1; m_req_at = mc + GAP + 1; end
        end
      end else if (req_prev && i2c_ready) begin
        m_wait = 1'b0; m_fly = 1'b1; m_acc = mc;
      end
    end
  end

  always @(negedge clk) begin
    bit er;
    er = m_wait && (mc >= m_req_at);
    if (m_valid && !rst) begin
      chk("req", i2c_req, er);
      chk("busy", busy, !(m_done || m_err));
      chk("init_done", init_done, m_done);
      chk("init_err", init_err, m_err);
      chk("step_idx", step, m_idx);
      chk("dev_addr", dev, 7'h1A);
      chk("done_err_excl", init_done & init_err, 0);
      if (er) chk("fields", {ra, wd}, tbl[m_idx]);
    end
  end

  // Behavioural I2C master: ready when idle, done+nack after ack_lat cycles
  bit          ms_busy = 1'b0;
  int          ms_lat = 0, ms_ent = 0, run = 0;
  bit          p_req = 1'b0, p_rdy = 1'b0;
  logic [15:0] p_fields = '0;
  int          p_step = 0;

  always @(negedge clk) begin
    if (rst) begin
      ms_busy = 1'b0; ms_lat = 0; p_req = 1'b0; p_rdy = 1'b0; run = 0;
      i2c_ready = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
    end else begin
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (p_req && p_rdy) begin
        acc_log.push_back(p_fields);
        acc_cyc.push_back(mc);
        acc_run.push_back(run);
        run = 0;
        ms_ent = p_step;
        ms_busy = !never_done;
        ms_lat = ack_lat;
      end else if (ms_busy) begin
        ms_lat--;
        if (ms_lat == 0) begin
          i2c_done = 1'b1;
          if (ms_ent < NW && nack_left[ms_ent] > 0) begin
            i2c_nack = 1'b1;
            nack_left[ms_ent]--;
          end
          ms_busy = 1'b0;
        end
      end
      if (i2c_req) begin
        run++;
        if (hold > 0) hold--;
      end
      i2c_ready = !ms_busy && (hold == 0);
      p_req = i2c_req;
      p_rdy = i2c_ready;
      p_fields = {ra, wd};
      p_step = int'(step);
    end
  end

  task automatic clear_cfg();
    for (int i = 0; i < NW; i++) nack_left[i] = 0;
    never_done = 1'b0;
    hold = 0;
    ack_lat = 50;
  endtask

  task automatic clear_log();
    acc_log.delete(); acc_cyc.delete(); acc_run.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_log();
    rst = 1'b0;
  endtask

  task automatic wait_end(input string name, input int maxc);
    int k;
    k = 0;
    while (!(init_done || init_err) && k < maxc) begin
      @(negedge clk); #1;
      k++;
    end
    chk({name, "_finished"}, (k < maxc), 1);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    int k;
    int rq;
    clear_cfg();

    // 1: clean run, table order, power-up delay
    do_reset();
    #1;
    chk("rst_req", i2c_req, 0);
    chk("rst_fields", {ra, wd}, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", init_done, 0);
    chk("rst_err", init_err, 0);
    chk("rst_step", step, 0);
    k = 0;
    while (!i2c_req && k < 100) begin @(negedge clk); #1; k++; end
    chk("first_req_21_22", (k >= 21 && k <= 22), 1);
    wait_end("t1", 2000);
    chk("t1_nwrites", acc_log.size(), 4);
    if (acc_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("t1_order", acc_log[i], tbl[i]);
    chk("t1_done", init_done, 1);
    chk("t1_step", step, 4);
    chk("t1_busy", busy, 0);

    // 2: one NACK on entry 2, reissued with the same fields after the gap
    clear_cfg(); nack_left[2] = 1;
    do_reset();
    wait_end("t2", 2000);
    chk("t2_nwrites", acc_log.size(), 5);
    if (acc_log.size() == 5) begin
      chk("t2_retry_same", acc_log[3], acc_log[2]);
      chk("t2_retry_val", acc_log[3], 16'h0E02);
      chk("t2_last", acc_log[4], 16'h1000);
      chk("t2_retry_spacing", acc_cyc[3] - acc_cyc[2], 57);
    end
    chk("t2_done", init_done, 1);
    chk("t2_err", init_err, 0);

    // 3: entry 1 NACKed on every attempt
    clear_cfg(); nack_left[1] = 3;
    do_reset();
    wait_end("t3", 2000);
    chk("t3_err", init_err, 1);
    chk("t3_step", step, 1);
    chk("t3_nwrites", acc_log.size(), 4);
    rq = 0;
    repeat (100) begin @(negedge clk); #1; if (i2c_req) rq++; end
    chk("t3_no_req", rq, 0);
    chk("t3_nwrites_after", acc_log.size(), 4);

    // 4: master never completes, every attempt times out
    clear_cfg(); never_done = 1'b1;
    do_reset();
    wait_end("t4", 3000);
    chk("t4_err", init_err, 1);
    chk("t4_step", step, 0);
    chk("t4_attempts", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("t4_spacing1", acc_cyc[1] - acc_cyc[0], 206);
      chk("t4_spacing2", acc_cyc[2] - acc_cyc[1], 206);
    end

    // 5: ready withheld for 500 request cycles
    clear_cfg(); hold = 500;
    do_reset();
    wait_end("t5", 3000);
    chk("t5_done", init_done, 1);
    chk("t5_err", init_err, 0);
    if (acc_run.size() > 0) chk("t5_req_held", acc_run[0], 500);
    else chk("t5_accepted", 0, 1);

    // 6: start ignored while busy, honoured in DONE; reset mid-ISSUE
    clear_cfg(); ack_lat = 80;
    clear_log();
    pulse_start();
    @(negedge clk); #1;
    chk("t6_restart_req", i2c_req, 1);
    chk("t6_restart_step", step, 0);
    repeat (20) @(negedge clk);
    pulse_start();
    #1;
    chk("t6_ignored_busy", busy, 1);
    wait_end("t6a", 2000);
    chk("t6_done", init_done, 1);
    chk("t6_nwrites", acc_log.size(), 4);
    hold = 100;
    clear_log();
    pulse_start();
    repeat (5) @(negedge clk);
    #1;
    chk("t6_holding_req", i2c_req, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("t6_rst_drops_req", i2c_req, 0);
    repeat (2) @(negedge clk);
    hold = 0;
    clear_log();
    rst = 1'b0;
    wait_end("t6b", 2000);
    chk("t6b_done", init_done, 1);
    chk("t6b_step", step, 4);
    if (acc_cyc.size() > 0) chk("t6b_first_accept", acc_cyc[0], 22);
    else chk("t6b_accepted", 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
